// File: rtl/rr_grant_scheduler.sv
// rr_grant_scheduler
// Round-robin arbiter that captures one winner out of N_REQ level-held
// requests, then issues a single-cycle grant to that winner exactly L cycles
// after the capture edge (L = 3, 4 or 5 from lat_sel). After the grant it
// waits for the winner to drop its request before it rotates the pointer
// and returns to idle.
//
// Ports:
//   clk      system clock, all logic on posedge
//   rst      synchronous active-high reset
//   req      request lines, held by each requester until its grant is seen
//   lat_sel  grant latency select: 0->3, 1->4, 2->5, 3->5
//   grant    one-hot, one-cycle grant pulse
//   gnt_id   index of the current/last winner
//   busy     high from request capture until the return to idle
//   abort    one-cycle pulse when the winner drops req before its grant
module rr_grant_scheduler #(
    parameter int N_REQ = 4,
    parameter int ID_W  = 2
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [N_REQ-1:0] req,
    input  logic [1:0]       lat_sel,
    output logic [N_REQ-1:0] grant,
    output logic [ID_W-1:0]  gnt_id,
    output logic             busy,
    output logic             abort
);
    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_WAIT  = 2'd1;
    localparam logic [1:0] S_GRANT = 2'd2;
    localparam logic [1:0] S_REL   = 2'd3;

    logic [1:0]       state_q, state_d;
    logic [ID_W-1:0]  ptr_q, ptr_d;
    logic [ID_W-1:0]  id_q, id_d;
    logic [1:0]       cnt_q, cnt_d;
    logic [N_REQ-1:0] grant_q, grant_d;
    logic             busy_q, busy_d;
    logic             abort_q, abort_d;

    logic [2*N_REQ-1:0] req_dbl;
    logic [N_REQ-1:0]   req_rot;
    logic               pick_vld;
    logic [ID_W-1:0]    pick_id;
    logic [N_REQ-1:0]   win_oh;
    logic               req_w;
    logic [ID_W-1:0]    ptr_nxt;

    // Rotate req so bit 0 is the requester at ptr; the lowest set bit of the
    // rotated vector is then the round-robin winner.
    assign req_dbl = {req, req} >> ptr_q;
    assign req_rot = req_dbl[N_REQ-1:0];

    always_comb begin
        pick_vld = 1'b0;
        pick_id  = '0;
        // Descending scan: the last hit written is the lowest rotated index.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req_rot[i]) begin
                pick_vld = 1'b1;
                pick_id  = ID_W'((int'(ptr_q) + i) % N_REQ);
            end
        end
    end

    always_comb begin
        win_oh = '0;
        for (int i = 0; i < N_REQ; i++) begin
            win_oh[i] = (id_q == ID_W'(i));
        end
    end

    assign req_w   = |(req & win_oh);
    assign ptr_nxt = (int'(id_q) == N_REQ - 1) ? '0 : id_q + ID_W'(1);

    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        id_d    = id_q;
        cnt_d   = cnt_q;
        grant_d = '0;
        busy_d  = busy_q;
        abort_d = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pick_vld) begin
                    id_d    = pick_id;
                    // Counter holds L-2: grant_q is loaded one edge before
                    // T+L so it is seen high at edge T+L.
                    case (lat_sel)
                        2'd0:    cnt_d = 2'd1;
                        2'd1:    cnt_d = 2'd2;
                        default: cnt_d = 2'd3;
                    endcase
                    busy_d  = 1'b1;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                if (!req_w) begin
                    busy_d  = 1'b0;
                    abort_d = 1'b1;
                    state_d = S_IDLE;
                end else if (cnt_q == 2'd0) begin
                    grant_d = win_oh;
                    state_d = S_GRANT;
                end else begin
                    cnt_d = cnt_q - 2'd1;
                end
            end
            S_GRANT: begin
                state_d = S_REL;
            end
            default: begin
                if (!req_w) begin
                    ptr_d   = ptr_nxt;
                    busy_d  = 1'b0;
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ptr_q   <= '0;
            id_q    <= '0;
            cnt_q   <= '0;
            grant_q <= '0;
            busy_q  <= 1'b0;
            abort_q <= 1'b0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            id_q    <= id_d;
            cnt_q   <= cnt_d;
            grant_q <= grant_d;
            busy_q  <= busy_d;
            abort_q <= abort_d;
        end
    end

    assign grant  = grant_q;
    assign gnt_id = id_q;
    assign busy   = busy_q;
    assign abort  = abort_q;
endmodule

// File: tb/tb_rr_grant_scheduler.sv
module tb_rr_grant_scheduler;
    localparam int N = 4;

    logic         clk = 1'b0;
    logic         rst;
    logic [N-1:0] req;
    logic [1:0]   lat_sel;
    logic [N-1:0] grant;
    logic [1:0]   gnt_id;
    logic         busy;
    logic         abort;

    rr_grant_scheduler #(.N_REQ(N), .ID_W(2)) dut (
        .clk(clk), .rst(rst), .req(req), .lat_sel(lat_sel),
        .grant(grant), .gnt_id(gnt_id), .busy(busy), .abort(abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit           is_abort;
        logic [N-1:0] vec;
        int           due;   // edge at which the pulse must be sampled high
    } ev_t;

    ev_t exp_q[$];
    int  checks = 0;
    int  errors = 0;
    int  cyc = 0;
    bit  mon_en = 1'b0;

    // Reference model: one transaction at a time, described by its capture
    // edge, its latency and its winner.
    bit   m_act = 1'b0;
    int   m_ptr = 0;
    int   m_w = 0;
    int   m_t = 0;
    int   m_lat = 0;
    logic [1:0] m_id = 2'd0;

    always @(posedge clk) begin
        int  idx;
        bit  found;
        cyc++;
        if (rst) begin
            m_act = 1'b0;
            m_ptr = 0;
            m_id  = 2'd0;
            for (int k = exp_q.size() - 1; k >= 0; k--)
                if (exp_q[k].due > cyc) exp_q.delete(k);
        end else if (!m_act) begin
            if (req != '0) begin
                found = 1'b0;
                for (int k = 0; k < N; k++) begin
                    idx = (m_ptr + k) % N;
                    if (!found && req[idx]) begin
                        found = 1'b1;
                        m_w = idx;
                    end
                end
                m_lat = (lat_sel == 2'd0) ? 3 : (lat_sel == 2'd1) ? 4 : 5;
                m_t   = cyc;
                m_act = 1'b1;
                m_id  = 2'(m_w);
                exp_q.push_back('{1'b0, N'(1) << m_w, cyc + m_lat});
            end
        end else if (cyc < m_t + m_lat) begin
            if (!req[m_w]) begin
                void'(exp_q.pop_back());
                exp_q.push_back('{1'b1, '0, cyc + 1});
                m_act = 1'b0;
            end
        end else if (cyc > m_t + m_lat) begin
            if (!req[m_w]) begin
                m_ptr = (m_w + 1) % N;
                m_act = 1'b0;
            end
        end
    end

    // Monitor: samples between edges; label s is the edge that will sample it.
    always @(negedge clk) begin
        int  s;
        ev_t e;
        if (mon_en) begin
            s = cyc + 1;
            while (exp_q.size() > 0 && exp_q[0].due < s) begin
                checks++;
                errors++;
                e = exp_q.pop_front();
                $display("FAIL missed_pulse: abort=%0b vec=%b due edge %0d, nothing seen", e.is_abort, e.vec, e.due);
            end
            if (grant != '0 || abort) begin
                checks++;
                if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL unexpected_pulse: edge %0d grant=%b abort=%b, none expected", s, grant, abort);
                end else begin
                    e = exp_q.pop_front();
                    if (e.due != s || abort != e.is_abort || grant != (e.is_abort ? '0 : e.vec)) begin
                        errors++;
                        $display("FAIL pulse: edge %0d grant=%b abort=%b, expected edge %0d grant=%b abort=%b",
                                 s, grant, abort, e.due, e.is_abort ? '0 : e.vec, e.is_abort);
                    end
                end
            end
            checks++;
            if (busy !== m_act) begin
                errors++;
                $display("FAIL busy: edge %0d got %b, expected %b", s, busy, m_act);
            end
            checks++;
            if (gnt_id !== m_id) begin
                errors++;
                $display("FAIL gnt_id: edge %0d got %0d, expected %0d", s, gnt_id, m_id);
            end
            checks++;
            if ($countones(grant) > 1 || (grant != '0 && abort)) begin
                errors++;
                $display("FAIL exclusive: edge %0d grant=%b abort=%b, expected <=1 grant bit and no abort with grant", s, grant, abort);
            end
        end
    end

    // Requesters: raise at random, drop one cycle after seeing their own grant,
    // occasionally give up early (abort). lat_sel and rst optionally randomized.
    task automatic run(input int n, input int raise_pct, input int abort_pct,
                       input bit rnd_lat, input bit rnd_rst);
        logic [N-1:0] g;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            g = grant;
            @(posedge clk);
            #1;
            for (int i = 0; i < N; i++) begin
                if (req[i] && g[i])
                    req[i] = 1'b0;
                else if (req[i] && ($urandom % 100) < abort_pct)
                    req[i] = 1'b0;
                else if (!req[i] && ($urandom % 100) < raise_pct)
                    req[i] = 1'b1;
            end
            if (rnd_lat) lat_sel = 2'($urandom);
            rst = rnd_rst ? (($urandom % 150) == 0) : 1'b0;
        end
    endtask

    initial begin
        rst = 1'b1;
        req = '0;
        lat_sel = 2'd0;
        @(posedge clk);
        #1 mon_en = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if (grant !== '0 || busy !== 1'b0 || abort !== 1'b0 || gnt_id !== 2'd0) begin
            errors++;
            $display("FAIL reset_state: grant=%b busy=%b abort=%b gnt_id=%0d, expected all 0", grant, busy, abort, gnt_id);
        end
        rst = 1'b0;
        // Single requester, latency 4.
        req = 4'b0001;
        lat_sel = 2'd1;
        run(15, 0, 0, 1'b0, 1'b0);
        // Latency sweep with a lone requester.
        for (int l = 0; l < 4; l++) begin
            lat_sel = 2'(l);
            req = 4'b0100;
            run(12, 0, 0, 1'b0, 1'b0);
        end
        // Fairness: all held, each drops after its own grant.
        req = 4'b1111;
        lat_sel = 2'd0;
        run(40, 0, 0, 1'b0, 1'b0);
        // Random traffic with latency changes, aborts and occasional reset.
        run(3000, 15, 2, 1'b1, 1'b1);
        // Drain: everything still held gets granted and released.
        rst = 1'b0;
        run(60, 0, 0, 1'b1, 1'b0);
        checks++;
        if (exp_q.size() != 0 || req != '0) begin
            errors++;
            $display("FAIL drain: %0d pulses outstanding, req=%b, expected 0 and 0000", exp_q.size(), req);
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule

// File: doc/rr_grant_scheduler.md
Name: rr_grant_scheduler

Overview:
- Arbitration stage that produces the req/grant handshake checked by the downstream `req |-> ##[3:5] grant` assertion bench.
- Accepts N request lines and picks one winner round-robin.
- Issues a single-cycle grant to the winner a programmable 3, 4 or 5 cycles after the request is captured, then waits for that requester to release its request.

Parameters:
- N_REQ, 4, number of requesters (2..16).
- ID_W, 2, width of gnt_id; must be at least clog2(N_REQ).

Ports:
- clk  in  1  system clock; all logic on posedge.
- rst  in  1  synchronous, active-high reset.
- req  in  N_REQ  request lines; level-held by each requester until its grant is seen.
- lat_sel  in  2  grant latency select: 0→3, 1→4, 2→5, 3→5 (clamped).
- grant  out  N_REQ  one-hot grant pulse, one cycle wide.
- gnt_id  out  ID_W  index of the current/last winner.
- busy  out  1  high from request capture until return to IDLE.
- abort  out  1  one-cycle pulse when the winner drops req before its grant.

Behaviour:
- Reset (rst high at a posedge):
  - Next cycle: grant=0, gnt_id=0, busy=0, abort=0, state=IDLE, rr pointer=0, latency counter=0.
  - Reset mid-operation discards any pending grant; no grant pulse may appear after rst is sampled.
- Latency definition:
  - Capture edge T is the posedge at which req is sampled non-zero in IDLE.
  - L is decoded from lat_sel, sampled only at T; later changes do not affect the grant in flight.
  - grant[w] must be high when sampled at edge T+L, and low at every other edge in T+1..T+L-1 and at T+L+1.
- Winner selection at T: the first set bit of req scanning upward from ptr and wrapping N_REQ-1→0.
- States:
  - IDLE: busy=0. If req≠0, latch winner w, gnt_id=w, load counter, go WAIT; busy=1 from edge T+1.
  - WAIT:
    - Counter runs down.
    - If req[w] is sampled low: go IDLE, pulse abort for one cycle, assert no grant, leave ptr unchanged.
    - Otherwise, when the count expires, drive grant[w]=1 so it is sampled at T+L, and go GRANT.
  - GRANT: one cycle only. grant returns to 0 at the next edge. Go RELEASE.
  - RELEASE:
    - grant=0. Stay while req[w]=1.
    - When req[w] is sampled 0: ptr=(w+1) mod N_REQ, go IDLE, busy=0.
    - The earliest next capture is the edge after IDLE is entered.
- Concurrency:
  - Requests on other lines during WAIT/GRANT/RELEASE are ignored; they stay pending because requesters hold req.
  - Never more than one grant bit high; never two grants within one busy interval.
- Wrap-around: with ptr=N_REQ-1 and req bits N_REQ-1 and 0 both set, N_REQ-1 wins; ptr then becomes 0.
- abort and grant are never high in the same cycle.
- gnt_id holds its value in IDLE and updates only at capture.

Test Plan:
- Single requester, latency 4: rst for 2 cycles; lat_sel=1, req=4'b0001 at edge 2, held until grant is seen, then dropped → grant=4'b0001 sampled only at edge 6; gnt_id=0; busy high edges 3..7; assertion ##[3:5] passes.
- Latency sweep: repeat with lat_sel=0, 2, 3 → grant at T+3, T+5, T+5. lat_sel changed to 0 mid-WAIT at lat_sel=2 → grant still at T+5.
- Round-robin fairness: req=4'b1111 held, each requester drops req one cycle after its own grant → grant order 0,1,2,3,0; gnt_id 0,1,2,3,0; no two grant bits high together.
- Wrap: ptr=3, req=4'b1001 → grant[3] first, then grant[0] in the next busy interval.
- Abort: req[2] alone, lat_sel=2, req[2] dropped at T+2 → abort pulse one cycle, no grant, busy=0, ptr unchanged. Re-raised req[2] is granted at its new T+5.
- Reset mid-WAIT: rst at T+2 with L=5 → grant stays 0 through T+8; all outputs 0 at T+3. A request held through reset is captured at the first IDLE edge after rst deasserts.
